// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
//   FWD_*       : forwarding mux selects driven on ForwardAE/ForwardBE
//   mul_state_e : state of the multiply-occupancy FSM
package hazard_pkg;
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_W    = 2'b01;
   localparam logic [1:0] FWD_M    = 2'b10;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_BUSY = 1'b1
   } mul_state_e;
endpackage

// File: rtl/hazard_if.sv
// hazard_if: bundle of pipeline-side signals seen by the hazard controller.
//   master : the pipeline (drives indices/enables/cache stalls, reads controls)
//   slave  : hazard_ctrl (reads pipeline state, drives forward/stall/flush/perf)
interface hazard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              RegWriteM, RegWriteW;
   logic [REG_AW-1:0] RdM, RdW, RdE;
   logic [REG_AW-1:0] Rs1E, Rs2E, Rs1D, Rs2D;
   logic              ResultSrcE0, PCSrcE, MulStartE;
   logic              iCacheStall, dCacheStall;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, StallE, StallM, StallW;
   logic              FlushD, FlushE, FlushM;
   logic              MulBusy, MulDoneE;
   logic [CNT_W-1:0]  StallCycles, FlushCount;

   modport master (
      output RegWriteM, RegWriteW, RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D,
             ResultSrcE0, PCSrcE, MulStartE, iCacheStall, dCacheStall,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, FlushM, MulBusy, MulDoneE, StallCycles, FlushCount
   );

   modport slave (
      input  RegWriteM, RegWriteW, RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D,
             ResultSrcE0, PCSrcE, MulStartE, iCacheStall, dCacheStall,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, FlushM, MulBusy, MulDoneE, StallCycles, FlushCount
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for the hazard perf counters.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count this cycle
//   cnt      : current value, holds at all-ones
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard controller.
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_if slave port carrying
//              - RAW forwarding selects into E (M priority over W)
//              - load-use stall, branch flush, I/D-cache stall handling
//              - multi-cycle multiply occupancy (internal latency FSM)
//              - saturating StallCycles / FlushCount perf counters
// All control outputs are combinational; only the FSM and counters are flops.
module hazard_ctrl import hazard_pkg::*; #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input logic    clk,
   input logic    rst,
   hazard_if.slave hz
);
   localparam int            CW        = $clog2(MUL_LAT);
   localparam logic [CW-1:0] CNT_START = CW'(MUL_LAT - 2);

   mul_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             lw_stall, mul_active, branch_flush;
   logic [1:0]       fwd_a, fwd_b;
   logic             stall_f, stall_d, stall_e, stall_m, stall_w;
   logic             flush_d, flush_e, flush_m, mul_busy, mul_done;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // ---- mul FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MUL_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---- mul FSM: next state; a D-cache stall freezes it completely ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!hz.dCacheStall) begin
         case (state_q)
            MUL_IDLE: if (hz.MulStartE) begin
               state_d = MUL_BUSY;
               cnt_d   = CNT_START;  // start cycle plus the zero cycle cover the other two
            end
            MUL_BUSY: begin
               if (cnt_q != '0) cnt_d   = cnt_q - CW'(1);
               else             state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
         endcase
      end
   end

   // ---- outputs ----
   always_comb begin
      lw_stall   = hz.ResultSrcE0 && ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
      // the cnt==0 cycle is the result cycle: E is released there
      mul_active = ((state_q == MUL_IDLE) && hz.MulStartE) ||
                   ((state_q == MUL_BUSY) && (cnt_q != '0));
      fwd_a = FWD_NONE;  fwd_b = FWD_NONE;
      stall_f = 1'b0;  stall_d = 1'b0;  stall_e = 1'b0;  stall_m = 1'b0;  stall_w = 1'b0;
      flush_d = 1'b0;  flush_e = 1'b0;  flush_m = 1'b0;
      mul_busy = 1'b0;  mul_done = 1'b0;  branch_flush = 1'b0;
      if (!rst) begin
         if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs1E))      fwd_a = FWD_M;
         else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs1E)) fwd_a = FWD_W;
         if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs2E))      fwd_b = FWD_M;
         else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs2E)) fwd_b = FWD_W;
         mul_busy = (state_q == MUL_BUSY);
         mul_done = (state_q == MUL_BUSY) && (cnt_q == '0);
         if (hz.dCacheStall) begin
            {stall_f, stall_d, stall_e, stall_m, stall_w} = '1;
         end else if (mul_active) begin
            // the multiply owns E; M gets bubbles while it is held
            {stall_f, stall_d, stall_e} = '1;
            flush_m = 1'b1;
         end else begin
            stall_f      = lw_stall | hz.iCacheStall;
            stall_d      = lw_stall;
            flush_e      = lw_stall | hz.PCSrcE;
            flush_d      = hz.PCSrcE | (hz.iCacheStall & ~lw_stall);
            branch_flush = hz.PCSrcE;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(stall_d), .cnt(stall_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .inc(branch_flush), .cnt(flush_cnt)
   );

   assign hz.ForwardAE   = fwd_a;
   assign hz.ForwardBE   = fwd_b;
   assign hz.StallF      = stall_f;
   assign hz.StallD      = stall_d;
   assign hz.StallE      = stall_e;
   assign hz.StallM      = stall_m;
   assign hz.StallW      = stall_w;
   assign hz.FlushD      = flush_d;
   assign hz.FlushE      = flush_e;
   assign hz.FlushM      = flush_m;
   assign hz.MulBusy     = mul_busy;
   assign hz.MulDoneE    = mul_done;
   assign hz.StallCycles = rst ? '0 : stall_cnt;
   assign hz.FlushCount  = rst ? '0 : flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
   localparam int CNT_W   = 8;
   localparam int MUL_LAT = 4;
   localparam int SAT     = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic sf, sd, se, sm, sw, fd, fe, fm, busy, done;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   // reference model state: cycles of E occupancy still owed, perf counts
   int rem = 0;
   int m_stall = 0;
   int m_flush = 0;

   always #5 clk = ~clk;

   hazard_if #(.REG_AW(5), .CNT_W(CNT_W)) hz ();

   hazard_ctrl #(.REG_AW(5), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hz(hz)
   );

   always @(negedge clk)
      if (!rst) assert (!(hz.PCSrcE && hz.MulStartE)) else $error("illegal PCSrcE with MulStartE");

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
      if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit ref_mact();
      return (rem == 0 && hz.MulStartE) || rem > 1;
   endfunction

   function automatic outs_t ref_out();
      outs_t o;
      bit lw;
      o = '0;
      if (rst) return o;
      lw = hz.ResultSrcE0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
      o.fa = ref_fwd(hz.Rs1E);
      o.fb = ref_fwd(hz.Rs2E);
      o.busy = rem > 0;
      o.done = rem == 1;
      if (hz.dCacheStall) begin
         {o.sf, o.sd, o.se, o.sm, o.sw} = 5'b11111;
      end else if (ref_mact()) begin
         {o.sf, o.sd, o.se, o.fm} = 4'b1111;
      end else begin
         o.sf = lw || hz.iCacheStall;
         o.sd = lw;
         o.fe = lw || hz.PCSrcE;
         o.fd = hz.PCSrcE || (hz.iCacheStall && !lw);
      end
      return o;
   endfunction

   function automatic outs_t dut_out();
      outs_t o;
      o = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
           hz.FlushD, hz.FlushE, hz.FlushM, hz.MulBusy, hz.MulDoneE};
      return o;
   endfunction

   // advance the model by one cycle from the current inputs, then clock
   task automatic tick();
      outs_t e;
      bit    mact;
      e    = ref_out();
      mact = ref_mact();
      if (rst) begin
         rem = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e.sd) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
         if (!hz.dCacheStall && !mact && hz.PCSrcE) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
         if (!hz.dCacheStall) begin
            if (rem == 0 && hz.MulStartE) rem = MUL_LAT - 1;
            else if (rem > 0)            rem = rem - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      hz.RegWriteM = 0; hz.RegWriteW = 0;
      hz.RdM = 0; hz.RdW = 0; hz.RdE = 0;
      hz.Rs1E = 0; hz.Rs2E = 0; hz.Rs1D = 0; hz.Rs2D = 0;
      hz.ResultSrcE0 = 0; hz.PCSrcE = 0; hz.MulStartE = 0;
      hz.iCacheStall = 0; hz.dCacheStall = 0;
   endtask

   task automatic rand_in(input bit allow_mul);
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3));
      hz.Rs2E = 5'($urandom_range(0, 3));
      hz.Rs1D = 5'($urandom_range(0, 3));
      hz.Rs2D = 5'($urandom_range(0, 3));
      hz.ResultSrcE0 = $urandom_range(0, 2) == 0;
      hz.PCSrcE      = $urandom_range(0, 4) == 0;
      hz.iCacheStall = $urandom_range(0, 4) == 0;
      hz.dCacheStall = $urandom_range(0, 6) == 0;
      hz.MulStartE   = allow_mul && rem == 0 && !hz.PCSrcE && $urandom_range(0, 3) == 0;
   endtask

   task automatic test_reset();
      rst = 1;
      rand_in(1);
      hz.PCSrcE = 0;
      @(negedge clk);
      checks++;
      if (dut_out() !== '0) begin
         failures++; $display("FAIL reset_outs got=%h exp=0", dut_out());
      end
      tick();
      rst = 0;
      idle_in();
      @(negedge clk);
      checks++;
      if (hz.StallCycles !== '0 || hz.FlushCount !== '0 || hz.MulBusy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", hz.StallCycles, hz.FlushCount, hz.MulBusy);
      end
      tick();
   endtask

   task automatic test_forwarding();
      idle_in();
      hz.RdM = 5; hz.RdW = 5; hz.RegWriteM = 1; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 0;
      @(negedge clk);
      checks++;
      if (hz.ForwardAE !== 2'b10 || hz.ForwardBE !== 2'b00) begin
         failures++; $display("FAIL fwd_m got=%b/%b exp=10/00", hz.ForwardAE, hz.ForwardBE);
      end
      tick();
      hz.RdM = 0;
      @(negedge clk);
      checks++;
      if (hz.ForwardAE !== 2'b01) begin
         failures++; $display("FAIL fwd_w got=%b exp=01", hz.ForwardAE);
      end
      tick();
      for (int i = 0; i < 40; i++) begin
         rand_in(0);
         @(negedge clk);
         checks++;
         if (hz.ForwardAE !== ref_fwd(hz.Rs1E) || hz.ForwardBE !== ref_fwd(hz.Rs2E)) begin
            failures++;
            $display("FAIL fwd_rand i=%0d got=%b/%b exp=%b/%b", i, hz.ForwardAE, hz.ForwardBE,
                     ref_fwd(hz.Rs1E), ref_fwd(hz.Rs2E));
         end
         tick();
      end
      idle_in();
      tick();
   endtask

   task automatic test_load_use();
      int pre;
      idle_in();
      hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 3; hz.Rs2D = 7;
      @(negedge clk);
      checks++;
      if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b1110) begin
         failures++;
         $display("FAIL load_use got=%b exp=1110", {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD});
      end
      pre = m_stall;
      tick();
      checks++;
      if (hz.StallCycles !== CNT_W'(pre + 1)) begin
         failures++; $display("FAIL load_use_cnt got=%0d exp=%0d", hz.StallCycles, pre + 1);
      end
      hz.PCSrcE = 1;
      pre = m_flush;
      @(negedge clk);
      checks++;
      if ({hz.FlushD, hz.FlushE} !== 2'b11) begin
         failures++; $display("FAIL branch_in_lw got=%b exp=11", {hz.FlushD, hz.FlushE});
      end
      tick();
      checks++;
      if (hz.FlushCount !== CNT_W'(pre + 1)) begin
         failures++; $display("FAIL flush_cnt got=%0d exp=%0d", hz.FlushCount, pre + 1);
      end
      idle_in();
      tick();
   endtask

   task automatic test_icache();
      idle_in();
      hz.iCacheStall = 1;
      @(negedge clk);
      checks++;
      if ({hz.StallF, hz.StallD, hz.FlushD} !== 3'b101) begin
         failures++; $display("FAIL icache got=%b exp=101", {hz.StallF, hz.StallD, hz.FlushD});
      end
      tick();
      idle_in();
      tick();
   endtask

   // {StallE, MulDoneE, FlushM, MulBusy, FlushE}; a load-use hazard is held the whole time
   task automatic test_mul();
      logic [4:0] exp_tab [5] = '{5'b10100, 5'b10110, 5'b10110, 5'b01011, 5'b00001};
      logic [4:0] got;
      idle_in();
      hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7;
      hz.MulStartE = 1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         got = {hz.StallE, hz.MulDoneE, hz.FlushM, hz.MulBusy, hz.FlushE};
         checks++;
         if (got !== exp_tab[t]) begin
            failures++; $display("FAIL mul t=%0d got=%b exp=%b", t, got, exp_tab[t]);
         end
         tick();
         hz.MulStartE = 0;
      end
      idle_in();
      tick();
   endtask

   // {StallF..StallW, FlushD, FlushE, FlushM, MulDoneE, MulBusy}
   task automatic test_mul_dcache();
      logic [9:0] exp_tab [7] = '{10'b11100_001_00, 10'b11111_000_01, 10'b11111_000_01,
                                  10'b11100_001_01, 10'b11100_001_01, 10'b00000_000_11,
                                  10'b00000_000_00};
      logic [9:0] got;
      int         fc0;
      idle_in();
      fc0 = m_flush;
      hz.MulStartE = 1;
      for (int t = 0; t < 7; t++) begin
         hz.dCacheStall = (t == 1 || t == 2);
         hz.PCSrcE      = (t == 1 || t == 2);
         @(negedge clk);
         got = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
                hz.FlushD, hz.FlushE, hz.FlushM, hz.MulDoneE, hz.MulBusy};
         checks++;
         if (got !== exp_tab[t]) begin
            failures++; $display("FAIL mul_dcache t=%0d got=%b exp=%b", t, got, exp_tab[t]);
         end
         tick();
         hz.MulStartE = 0;
      end
      idle_in();
      checks++;
      if (hz.FlushCount !== CNT_W'(fc0)) begin
         failures++; $display("FAIL mul_dcache_flushcnt got=%0d exp=%0d", hz.FlushCount, fc0);
      end
      tick();
   endtask

   task automatic test_random();
      outs_t e;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         rand_in(1);
         @(negedge clk);
         e = ref_out();
         checks++;
         if (dut_out() !== e) begin
            failures++; $display("FAIL rand_outs i=%0d got=%h exp=%h", i, dut_out(), e);
         end
         checks++;
         if (!rst && (hz.StallCycles !== CNT_W'(m_stall) || hz.FlushCount !== CNT_W'(m_flush))) begin
            failures++;
            $display("FAIL rand_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, hz.StallCycles,
                     hz.FlushCount, m_stall, m_flush);
         end
         tick();
      end
      rst = 0;
      idle_in();
      repeat (MUL_LAT + 1) tick();
   endtask

   task automatic test_saturation();
      idle_in();
      hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
      repeat ((1 << CNT_W) + 3) tick();
      @(negedge clk);
      checks++;
      if (hz.StallCycles !== {CNT_W{1'b1}} || hz.FlushCount !== {CNT_W{1'b1}}) begin
         failures++;
         $display("FAIL saturate got=%0d/%0d exp=%0d/%0d", hz.StallCycles, hz.FlushCount, SAT, SAT);
      end
      rst = 1;
      @(negedge clk);
      checks++;
      if (dut_out() !== '0 || hz.StallCycles !== '0 || hz.FlushCount !== '0) begin
         failures++; $display("FAIL reset_live got=%h exp=0", dut_out());
      end
      tick();
      rst = 0;
      idle_in();
      @(negedge clk);
      checks++;
      if (hz.StallCycles !== '0 || hz.FlushCount !== '0) begin
         failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hz.StallCycles, hz.FlushCount);
      end
      tick();
   endtask

   initial begin
      idle_in();
      @(posedge clk);
      #1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_icache();
      test_mul();
      test_mul_dcache();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
